// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Contents: result-source encoding, load funct3 codes, and the W-slot
// state encoding that is reported on the debug output.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_CSR  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_ACTIVE = 2'b01,
        W_WAIT   = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_if.sv
// Bus bundle between the memory stage / data memory and the writeback unit.
// master : drives the M-stage fields and the load response, observes the
//          stall, register-file write port, debug state and retire count.
// slave  : the writeback unit.
interface wb_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
);
    logic                      valid_M;
    logic                      reg_write_M;
    logic [REG_ADDR_WIDTH-1:0] rd_M;
    logic [1:0]                result_src_M;
    logic [2:0]                funct3_M;
    logic [1:0]                addr_low_M;
    logic [DAT_WIDTH-1:0]      alu_result_M;
    logic [ADDR_WIDTH-1:0]     pc_4M;
    logic [DAT_WIDTH-1:0]      csr_rdata_M;
    logic                      rvalid_i;
    logic [DAT_WIDTH-1:0]      rdata_i;
    logic                      stall_o;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr;
    logic [DAT_WIDTH-1:0]      rf_wdata;
    logic [1:0]                wb_state_o;
    logic [CNT_WIDTH-1:0]      instret_o;

    modport master (
        output valid_M, reg_write_M, rd_M, result_src_M, funct3_M, addr_low_M,
               alu_result_M, pc_4M, csr_rdata_M, rvalid_i, rdata_i,
        input  stall_o, rf_we, rf_waddr, rf_wdata, wb_state_o, instret_o
    );

    modport slave (
        input  valid_M, reg_write_M, rd_M, result_src_M, funct3_M, addr_low_M,
               alu_result_M, pc_4M, csr_rdata_M, rvalid_i, rdata_i,
        output stall_o, rf_we, rf_waddr, rf_wdata, wb_state_o, instret_o
    );
endinterface

// File: rtl/writeback_unit_load_extend.sv
// Combinational load-data extraction (byte / half / word, sign or zero
// extended). Shared with the forwarding unit.
// Ports: i_funct3 load type, i_addr_low address bits [1:0],
//        i_rdata raw memory word, o_data extended result.
module load_extend
    import wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_low,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_low)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Bit 0 of the address is ignored for halves: misaligned
        // halfword accesses are trapped earlier, not here.
        w_half = i_addr_low[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = 32'($signed(w_byte));
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LH:   o_data = 32'($signed(w_half));
            F3_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: holds the M/W pipeline register, selects the result
// (ALU, extracted load, PC+4, CSR), stalls on late load responses, drives
// the register-file write port and counts retired instructions.
// Ports: clk, rst_n (async active-low), bus (wb_if.slave) carrying the
// M-stage fields, load response, stall, rf write port, debug state and
// retire counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
) (
    input logic  clk,
    input logic  rst_n,
    wb_if.slave  bus
);
    // W pipeline register
    logic                      r_valid_W;
    logic                      r_reg_write_W;
    logic [REG_ADDR_WIDTH-1:0] r_rd_W;
    result_src_e               r_src_W;
    logic [2:0]                r_funct3_W;
    logic [1:0]                r_addr_low_W;
    logic [DAT_WIDTH-1:0]      r_alu_W;
    logic [ADDR_WIDTH-1:0]     r_pc4_W;
    logic [DAT_WIDTH-1:0]      r_csr_W;
    wb_state_e                 r_state;
    logic [CNT_WIDTH-1:0]      r_instret;

    logic                 w_is_load;
    logic                 w_stall;
    logic                 w_complete;
    logic                 w_valid_next;
    logic                 w_load_next;
    logic [31:0]          w_load_data;
    logic [DAT_WIDTH-1:0] w_wdata;

    load_extend u_load_extend (
        .i_funct3   (r_funct3_W),
        .i_addr_low (r_addr_low_W),
        .i_rdata    (bus.rdata_i),
        .o_data     (w_load_data)
    );

    assign w_is_load  = r_valid_W && (r_src_W == RES_LOAD);
    assign w_stall    = w_is_load && !bus.rvalid_i;
    assign w_complete = r_valid_W && !w_stall;

    // While stalled the slot keeps its load, so the next state stays WAIT.
    assign w_valid_next = w_stall ? r_valid_W : bus.valid_M;
    assign w_load_next  = w_stall ? 1'b1
                                  : (bus.valid_M && (bus.result_src_M == RES_LOAD));

    always_comb begin
        w_wdata = r_alu_W;
        case (r_src_W)
            RES_ALU:  w_wdata = r_alu_W;
            RES_LOAD: w_wdata = w_load_data;
            RES_PC4:  w_wdata = DAT_WIDTH'(r_pc4_W);
            default:  w_wdata = r_csr_W;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_W     <= 1'b0;
            r_reg_write_W <= 1'b0;
            r_rd_W        <= '0;
            r_src_W       <= RES_ALU;
            r_funct3_W    <= '0;
            r_addr_low_W  <= '0;
            r_alu_W       <= '0;
            r_pc4_W       <= '0;
            r_csr_W       <= '0;
            r_state       <= W_IDLE;
            r_instret     <= '0;
        end else begin
            if (!w_stall) begin
                r_valid_W     <= bus.valid_M;
                r_reg_write_W <= bus.reg_write_M;
                r_rd_W        <= bus.rd_M;
                r_src_W       <= result_src_e'(bus.result_src_M);
                r_funct3_W    <= bus.funct3_M;
                r_addr_low_W  <= bus.addr_low_M;
                r_alu_W       <= bus.alu_result_M;
                r_pc4_W       <= bus.pc_4M;
                r_csr_W       <= bus.csr_rdata_M;
            end
            if (!w_valid_next)
                r_state <= W_IDLE;
            else if (w_load_next)
                r_state <= W_WAIT;
            else
                r_state <= W_ACTIVE;
            if (w_complete)
                r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign bus.stall_o    = w_stall;
    assign bus.rf_we      = r_valid_W && r_reg_write_W && (r_rd_W != '0) && !w_stall;
    assign bus.rf_waddr   = r_rd_W;
    assign bus.rf_wdata   = w_wdata;
    // A response arriving this cycle completes the load, so report ACTIVE.
    assign bus.wb_state_o = ((r_state == W_WAIT) && bus.rvalid_i) ? W_ACTIVE : r_state;
    assign bus.instret_o  = r_instret;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Parametrised next-generation writeback stage for the pipelined RISC-V core. It holds the M/W pipeline register internally and selects the result from four sources: ALU, load, PC+4 and CSR. Load data is byte/half/word extracted with sign or zero extension. A load whose memory response is late stalls the pipeline. The block drives the register-file write port and keeps a retired-instruction counter.

Parameters:
ADDR_WIDTH, 32, PC width
DAT_WIDTH, 32, datapath width; must be 32 (word-extraction rules below)
REG_ADDR_WIDTH, 5, register index width
CNT_WIDTH, 64, retire counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_M  in  1  M-stage slot holds an instruction
reg_write_M  in  1  instruction writes rd
rd_M  in  REG_ADDR_WIDTH  destination register
result_src_M  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR
funct3_M  in  3  load type
addr_low_M  in  2  load address bits [1:0]
alu_result_M  in  DAT_WIDTH  ALU result
pc_4M  in  ADDR_WIDTH  PC+4
csr_rdata_M  in  DAT_WIDTH  CSR read value
rvalid_i  in  1  load response valid
rdata_i  in  DAT_WIDTH  raw load word
stall_o  out  1  hold M and earlier stages
rf_we  out  1  register-file write enable
rf_waddr  out  REG_ADDR_WIDTH  write index
rf_wdata  out  DAT_WIDTH  write data
wb_state_o  out  2  current FSM state, for debug
instret_o  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): W register cleared (valid_W=0, all fields 0); state W_IDLE; instret_o=0. Consequently stall_o=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- W register: on each rising edge with stall_o=0, captures all *_M fields. With stall_o=1 it holds.
- is_load_W = valid_W & (result_src_W==01).
- stall_o (combinational) = is_load_W & !rvalid_i.
- Completion: a valid_W instruction completes in a cycle where stall_o=0.
- Latency: non-load results reach rf_* one cycle after capture. A load writes in the first cycle rvalid_i=1 while it sits in W; zero-wait response is allowed.
- Register-file write:
  - rf_we = valid_W & reg_write_W & (rd_W!=0) & !stall_o.
  - rf_waddr = rd_W.
  - rf_wdata = the selected source (ALU, load-extracted, zero-extended PC+4, CSR).
- Load extraction, using off = addr_low_W:
  - LB (000) / LBU (100): byte off, sign- or zero-extended.
  - LH (001) / LHU (101): half at addr_low_W[1]; bit 0 ignored, so misalignment is not trapped here.
  - LW (010) and any other funct3: whole word.
- rvalid_i when no load is in W: ignored.
- rvalid_i is sampled only combinationally; the block has no data buffering. The memory must hold rdata_i valid for the same cycle as rvalid_i.
- FSM, a registered view of the W slot:
  - W_IDLE (00): no valid instruction in W.
  - W_ACTIVE (01): non-load, or load completing.
  - W_WAIT (10): load stalled.
  - Next state is computed from the post-edge W contents and the next-cycle rvalid_i expectation. Implement it as: next = !valid_next ? IDLE : (load_next ? WAIT : ACTIVE).
  - WAIT → ACTIVE is forced combinationally, i.e. wb_state_o reports ACTIVE in any cycle where rvalid_i completes the load.
- instret_o increments by 1 on every completing valid_W instruction, including rd=x0 or reg_write=0. It wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-stall: the pending load is dropped and no write occurs.

Decomposition:
- Package wb_pkg:
  - result_src enum (RES_ALU, RES_LOAD, RES_PC4, RES_CSR).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state enum (W_IDLE, W_ACTIVE, W_WAIT).
- One sub-module, load_extend: purely combinational (funct3, addr_low, rdata) → extended word. It is reusable by the forwarding unit.

Test Plan:
1. ALU op: valid_M=1, reg_write=1, rd=5, src=00, alu=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, instret 0→1.
2. LB with off=3, rdata=0x80FF_0000, rvalid on entry → rf_wdata=0xFFFF_FF80, no stall. Repeat as LBU → 0x0000_0080.
3. LH with 3-cycle late response: stall_o=1 for 3 cycles, rf_we=0, inputs held. rvalid with rdata=0x8001_0000, off=2 → rf_wdata=0xFFFF_8001. instret increments exactly once.
4. rd=x0 with src=10 → rf_we=0, instret still increments. Stray rvalid_i with no load in W → no effect.
5. Reset pulsed during W_WAIT → all outputs 0 immediately (async). After release, state W_IDLE and no write occurs.
6. Preload instret to 2^CNT_WIDTH−1 (force, or small CNT_WIDTH=4 with 16 completions) → wraps to 0.
